// File: rtl/apb_cmd_master.sv
// APB command master: one outstanding transfer, min 4 cycles per command (accept, SETUP, ACCESS, RESP).
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Counter only has to reach TIMEOUT-1: the check happens before the increment.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign req_ready   = (state == IDLE) && !preset;
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);
  assign pwrite      = cmd_q.write;
  assign paddr       = cmd_q.addr;
  assign pwdata      = cmd_q.wdata;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cmd_q       <= '0;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd_q    <= {req_write, req_addr, req_wdata};
            wait_cnt <= '0;
            psel     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing on the same cycle
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= cmd_q.write ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: vector table through a scoreboard, plus backpressure and mid-transfer reset sequences.
module tb_apb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] srdata;
    logic        serr;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_en;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          en;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        vecs[8];
  vec_t        v;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          slv_waits = 0;
  int          acc_cnt = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  logic        cur_write = 1'b0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  int          en_cnt = 0;
  int          setup_cnt = 0;
  int          last_acc = 0;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Slave: answers after slv_waits wait states, drives misleading values outside ACCESS.
  always @(posedge pclk) begin
    #1;
    if (psel && penable) begin
      if (acc_cnt == slv_waits) begin
        pready  = 1'b1;
        prdata  = slv_rdata;
        pslverr = slv_err;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'b1;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hDEAD_BEEF;
    end
  end

  // Monitor: APB phase accounting, address/data checks and response scoreboard.
  always @(negedge pclk) begin
    if (preset) begin
      exp_q.delete();
      en_cnt    = 0;
      setup_cnt = 0;
    end else begin
      if (psel && penable) en_cnt++;
      if (psel && !penable) setup_cnt++;
      if (psel) begin
        chk("paddr", paddr, cur_addr);
        chk1("pwrite", pwrite, cur_write);
        chk("pwdata", pwdata, cur_wdata);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_without_cmd", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk1("rsp_err", rsp_err, mon_e.err);
          chk1("rsp_timeout", rsp_timeout, mon_e.to);
          chk("penable_cycles", en_cnt, mon_e.en);
          chk("setup_cycles", setup_cnt, 1);
          chk1("psel_in_resp", psel, 1'b0);
          chk1("penable_in_resp", penable, 1'b0);
        end
        en_cnt    = 0;
        setup_cnt = 0;
      end
    end
  end

  task automatic send(input vec_t cv, output int waited);
    slv_waits = cv.waits;
    slv_rdata = cv.srdata;
    slv_err   = cv.serr;
    req_write = cv.write;
    req_addr  = cv.addr;
    req_wdata = cv.wdata;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(posedge pclk); #1;
      waited++;
    end
    chk1("req_accept", req_ready, 1'b1);
    cur_write = cv.write;
    cur_addr  = cv.addr;
    cur_wdata = cv.wdata;
    exp_q.push_back('{cv.e_rdata, cv.e_err, cv.e_to, cv.e_en});
    last_acc = cyc + 1;
    @(posedge pclk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge pclk); #1;
      n++;
    end
    chk({name, "_rsp_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, n, a1, seen;
    //          wr    addr          wdata         waits srdata        serr  e_rdata       err   to    en
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 0,   32'hFFFF_0000, 1'b0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 3,   32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h1111_1111, 1,   32'hCAFE_0002, 1'b1, 32'hCAFE_0002, 1'b1, 1'b0, 2};
    vecs[3] = '{1'b1, 32'h0000_0024, 32'h0000_5A5A, 2,   32'h7777_7777, 1'b1, 32'h0,        1'b1, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h0000_0028, 32'h0000_0000, 255, 32'h9999_9999, 1'b0, 32'h0,        1'b1, 1'b1, 16};
    vecs[5] = '{1'b0, 32'h0000_002C, 32'h0000_0000, 15,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, 16};
    vecs[6] = '{1'b0, 32'h0000_0030, 32'h0000_0000, 16,  32'h5555_AAAA, 1'b0, 32'h0,        1'b1, 1'b1, 16};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0,   32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1};

    repeat (2) @(posedge pclk);
    #1;
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_psel", psel, 1'b0);
    chk1("rst_penable", penable, 1'b0);
    chk1("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_rsp_timeout", rsp_timeout, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    preset = 1'b0;
    #1;
    chk1("idle_req_ready", req_ready, 1'b1);

    send(vecs[0], w);
    chk("first_accept_wait", w, 0);
    a1 = last_acc;
    wait_rsp("v0");
    send(vecs[7], w);
    chk("min_period", last_acc - a1, 4);
    wait_rsp("v7");

    for (int i = 1; i < 7; i++) begin
      send(vecs[i], w);
      wait_rsp("vec");
    end

    // Response backpressure with a competing command waiting
    rsp_ready = 1'b0;
    v = '{1'b0, 32'h0000_0040, 32'h0, 0, 32'h1111_2222, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 1};
    send(v, w);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0080;
    req_wdata = 32'h0BAD_0BAD;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge pclk); #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1111_2222);
      chk1("bp_rsp_err", rsp_err, 1'b0);
      chk1("bp_rsp_timeout", rsp_timeout, 1'b0);
      chk1("bp_req_ready", req_ready, 1'b0);
      chk1("bp_psel", psel, 1'b0);
      @(posedge pclk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_rsp("bp");
    seen = 0;
    repeat (3) begin
      @(posedge pclk); #1;
      if (rsp_valid || psel) seen++;
    end
    chk("bp_no_extra_activity", seen, 0);

    // Reset in the middle of ACCESS
    v = '{1'b0, 32'h0000_0050, 32'h0, 255, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 16};
    send(v, w);
    n = 0;
    while (!penable && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    chk1("rst_mid_in_access", penable, 1'b1);
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    chk1("midrst_psel", psel, 1'b0);
    chk1("midrst_penable", penable, 1'b0);
    chk1("midrst_rsp_valid", rsp_valid, 1'b0);
    chk1("midrst_req_ready", req_ready, 1'b0);
    chk("midrst_paddr", paddr, 32'h0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
    preset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge pclk); #1;
      if (rsp_valid || psel) seen++;
    end
    chk("midrst_discarded", seen, 0);
    v = '{1'b1, 32'h0000_0060, 32'h600D_0060, 1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2};
    send(v, w);
    wait_rsp("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter: ADDR_W, 32, APB address width.
REQ-002 Parameter: DATA_W, 32, APB data width.
REQ-003 Parameter: TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 = timeout disabled.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 pclk  in  1  clock; all state changes on rising edge.
REQ-006 preset  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  command present.
REQ-008 req_ready  out  1  command accepted when req_valid && req_ready at pclk edge.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  target address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
REQ-015 rsp_err  out  1  pslverr seen or timeout.
REQ-016 rsp_timeout  out  1  transfer aborted by timeout.
REQ-017 psel, penable, pwrite  out  1 each  APB master controls.
REQ-018 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address/write data.
REQ-019 pready, pslverr  in  1 each; prdata  in  DATA_W  APB slave returns.

Function
REQ-020 FSM states IDLE, SETUP, ACCESS, RESP; only one transfer outstanding.
REQ-021 req_ready SHALL be 1 exactly when state==IDLE and preset==0 (combinational from state).
REQ-022 IDLE: on accept, register write/addr/wdata, go SETUP next edge.
REQ-023 SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from registered command; always go ACCESS after one cycle.
REQ-024 ACCESS: psel=1, penable=1; stay while pready=0 and timeout not reached.
REQ-025 ACCESS with pready=1: capture prdata (reads only, else 0) into rsp_rdata, pslverr into rsp_err, rsp_timeout=0; go RESP.
REQ-026 Wait counter clears on SETUP entry, increments each ACCESS cycle with pready=0; when it reaches TIMEOUT (TIMEOUT>0): go RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 pready on the cycle the counter reaches TIMEOUT wins: normal completion, no timeout.
REQ-028 RESP: psel=0, penable=0, rsp_valid=1; rsp_* stable until rsp_ready=1, then IDLE next edge.
REQ-029 psel/penable SHALL be 0 in IDLE and RESP; paddr/pwrite/pwdata hold last values outside SETUP/ACCESS.
REQ-030 pready, prdata, pslverr SHALL be ignored outside ACCESS; pslverr sampled only with pready=1.
REQ-031 Minimum transfer period with rsp_ready tied high: 4 cycles (IDLE accept, SETUP, ACCESS, RESP).
REQ-032 req_* inputs SHALL be ignored outside IDLE; no command is lost or duplicated.

Reset
REQ-033 preset=1 at an edge: state=IDLE, counter=0, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0.
REQ-034 Reset mid-transfer (SETUP/ACCESS/RESP): psel/penable low after that edge; in-flight response discarded, never presented.
REQ-035 First accept possible on first edge with preset=0 and req_valid=1.

Verification
REQ-036 Write addr 0x10 data 0xA5A5_0001, slave pready=1 immediate -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-037 Read addr 0x14, slave returns 0x1234_5678 after 3 wait states -> penable high 4 cycles, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-038 Read with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
REQ-039 pready held low, TIMEOUT=16 -> after 16 ACCESS cycles psel drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-040 rsp_ready low 5 cycles with req_valid high -> rsp fields stable, req_ready=0, no APB activity until rsp handshake.
REQ-041 preset asserted during ACCESS -> next edge psel=penable=0, rsp_valid=0; next command completes normally.
